// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: synchronizes and glitch-filters SCL/SDA, detects START/STOP,
// shifts data bytes in MSB first and drives the ACK slot. No address phase.
module i2c_slave_rx #(
    parameter int  FILT_LEN  = 3,
    parameter int  MAX_BYTES = 16,
    localparam int IDX_W     = $clog2(MAX_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_t,
    input  logic             ack_en,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [IDX_W-1:0] rx_byte_idx,
    output logic             start_det,
    output logic             stop_det,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RX, ACK} state_t;

    localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_BYTES - 1);

    state_t           state, state_nx;
    logic [1:0]       scl_sync, sda_sync;
    logic [3:0]       scl_cnt, sda_cnt;
    logic             scl_f, sda_f;
    logic             scl_d, sda_d;
    logic             scl_rise, scl_fall, sda_rise, sda_fall;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             ack_q;
    logic [IDX_W-1:0] byte_idx;

    logic start_ev, stop_ev, shift_en, byte_done, ack_drive, ack_end;

    assign sda_o       = 1'b0;
    assign rx_byte_idx = byte_idx;

    // Synchronizers and filters reset to 1 so a reset never manufactures a bus edge.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};

            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end

            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    // scl_d/sda_d are the filtered levels aligned with the registered edge flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_rise <= 1'b0;
            sda_fall <= 1'b0;
        end else begin
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            scl_rise <= scl_f & ~scl_d;
            scl_fall <= ~scl_f & scl_d;
            sda_rise <= sda_f & ~sda_d;
            sda_fall <= ~sda_f & sda_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        start_ev  = 1'b0;
        stop_ev   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ack_drive = 1'b0;
        ack_end   = 1'b0;
        if (sda_rise && scl_d) begin
            stop_ev  = 1'b1;
            state_nx = IDLE;
        end else if (sda_fall && scl_d) begin
            start_ev = 1'b1;
            state_nx = RX;
        end else begin
            case (state)
                IDLE: ;
                RX: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_en  = 1'b1;
                        byte_done = (bit_cnt == 4'd7);
                    end
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx  = ACK;
                        ack_drive = ack_q;
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        state_nx = RX;
                        ack_end  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            ack_q     <= 1'b0;
            byte_idx  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
            sda_t     <= 1'b1;
        end else begin
            rx_valid  <= byte_done;
            start_det <= start_ev;
            stop_det  <= stop_ev;
            if (start_ev)     busy <= 1'b1;
            else if (stop_ev) busy <= 1'b0;

            if (start_ev || stop_ev) begin
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                if (start_ev) byte_idx <= '0;
            end else begin
                if (shift_en) begin
                    shreg   <= {shreg[6:0], sda_d};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (byte_done) begin
                    rx_data <= {shreg[6:0], sda_d};
                    ack_q   <= ack_en;
                end
                if (ack_drive) sda_t <= 1'b0;
                if (ack_end) begin
                    sda_t   <= 1'b1;
                    bit_cnt <= '0;
                    if (byte_idx != IDX_MAX) byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: a behavioural I2C master drives byte frames
// and the expected bytes, indices, ACK slots and strobes are derived from the frame contents.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

    localparam int MAX_BYTES = 16;
    localparam int IDX_W     = $clog2(MAX_BYTES);
    localparam int Q         = 100;   // master quarter-bit step in ns

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic ack_en = 1'b1;

    logic             sda_o, sda_t, rx_valid, start_det, stop_det, busy;
    logic [7:0]       rx_data;
    logic [IDX_W-1:0] rx_byte_idx;

    // Open-drain bus: the line is low if either side pulls it low.
    wire sda_line = sda_m & (sda_t | sda_o);

    always #5 clk = ~clk;

    i2c_slave_rx #(.FILT_LEN(3), .MAX_BYTES(MAX_BYTES)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
        .sda_o(sda_o), .sda_t(sda_t), .ack_en(ack_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_byte_idx(rx_byte_idx),
        .start_det(start_det), .stop_det(stop_det), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         idx_q[$];
    int         n_start, n_stop, n_drive;
    logic [7:0] tx_q[$];
    int         ack_drv_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            idx_q.push_back(int'(rx_byte_idx));
        end
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (!sda_t)    n_drive++;
    end

    localparam logic [IDX_W+14:0] RESET_VEC = {1'b0, 1'b1, 8'h00, 1'b0, {IDX_W{1'b0}}, 1'b0, 1'b0, 1'b0};
    function automatic logic [IDX_W+14:0] out_vec();
        return {sda_o, sda_t, rx_data, rx_valid, rx_byte_idx, start_det, stop_det, busy};
    endfunction

    task automatic clear_mon();
        rx_q.delete(); idx_q.delete();
        n_start = 0; n_stop = 0; n_drive = 0;
    endtask

    task automatic align();
        #(Q - int'($time % Q));
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b, input int glitch);
        sda_m = b; #Q; scl_m = 1'b1;
        if (glitch > 0) begin
            #(Q/2); scl_m = 1'b0; #(10*glitch); scl_m = 1'b1; #(Q + Q/2 - 10*glitch);
        end else begin
            #(2*Q);
        end
        scl_m = 1'b0; #Q;
    endtask

    // Sends 8 data bits plus the ACK clock; counts sda_t samples across the 9th SCL high.
    task automatic send_byte(input logic [7:0] d, input int glitch_bit, input int glitch_len,
                             output int drv_cnt);
        for (int i = 7; i >= 0; i--) send_bit(d[i], (i == glitch_bit) ? glitch_len : 0);
        sda_m = 1'b1; #Q; scl_m = 1'b1;
        drv_cnt = 0;
        #2;
        for (int k = 0; k < 20; k++) begin
            if (!sda_t) drv_cnt++;
            if (k < 19) #10;
        end
        #8; scl_m = 1'b0; #Q;
    endtask

    task automatic send_frame(input int glitch_bit, input int glitch_len);
        int drv;
        clear_mon();
        ack_drv_q.delete();
        bus_start();
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], (i == 0) ? glitch_bit : -1, glitch_len, drv);
            ack_drv_q.push_back(drv);
        end
        bus_stop();
        #(4*Q);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
        end
        @(posedge clk); #1 rst = 1'b0;
        align();
        #(4*Q);
    endtask

    task automatic test_single();
        int drv;
        logic [7:0] got;
        ack_en = 1'b1;
        clear_mon();
        bus_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", busy); end
        send_byte(8'hA5, -1, 0, drv);
        bus_stop();
        #(4*Q);
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        checks++; if (n_start !== 1) begin errors++; $display("FAIL single_start: got %0d expected 1", n_start); end
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", got); end
        checks++; if (idx_q.size() < 1 || idx_q[0] !== 0) begin errors++; $display("FAIL single_idx: expected 0"); end
        checks++; if (drv !== 20) begin errors++; $display("FAIL single_ack_slot: got %0d low samples expected 20", drv); end
        checks++; if (n_stop !== 1) begin errors++; $display("FAIL single_stop: got %0d expected 1", n_stop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    // Reference model: bytes arrive in order, index = min(position, MAX_BYTES-1),
    // every ACK slot fully low when ack_en is set and fully released otherwise.
    task automatic check_frame_model(input string name, input int n_starts);
        logic [7:0] got;
        int gi;
        int exp_drv;
        exp_drv = ack_en ? 20 : 0;
        checks++;
        if (rx_q.size() !== tx_q.size()) begin
            errors++; $display("FAIL %s_count: got %0d expected %0d", name, rx_q.size(), tx_q.size());
        end
        foreach (tx_q[i]) begin
            got = (i < rx_q.size()) ? rx_q[i] : 'x;
            gi  = (i < idx_q.size()) ? idx_q[i] : -1;
            checks++;
            if (got !== tx_q[i]) begin errors++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got, tx_q[i]); end
            checks++;
            if (gi !== ((i < MAX_BYTES - 1) ? i : MAX_BYTES - 1)) begin
                errors++; $display("FAIL %s_idx[%0d]: got %0d expected %0d", name, i, gi, (i < MAX_BYTES - 1) ? i : MAX_BYTES - 1);
            end
            checks++;
            if (ack_drv_q[i] !== exp_drv) begin
                errors++; $display("FAIL %s_ack[%0d]: got %0d low samples expected %0d", name, i, ack_drv_q[i], exp_drv);
            end
        end
        checks++; if (n_start !== n_starts) begin errors++; $display("FAIL %s_start: got %0d expected %0d", name, n_start, n_starts); end
        checks++; if (n_stop !== 1) begin errors++; $display("FAIL %s_stop: got %0d expected 1", name, n_stop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b expected 0", name, busy); end
    endtask

    task automatic test_multi();
        ack_en = 1'b1;
        tx_q = '{8'h12, 8'h34, 8'h56};
        send_frame(-1, 0);
        check_frame_model("multi", 1);
    endtask

    task automatic test_nack();
        ack_en = 1'b0;
        tx_q = '{8'h3C};
        send_frame(-1, 0);
        check_frame_model("nack", 1);
        checks++;
        if (n_drive !== 0) begin errors++; $display("FAIL nack_sda_t: got %0d driven cycles expected 0", n_drive); end
        ack_en = 1'b1;
    endtask

    task automatic test_glitch();
        logic bits[$];
        logic [7:0] exp;
        logic [7:0] got;
        ack_en = 1'b1;
        tx_q = '{8'hA5};
        send_frame(4, 2);
        check_frame_model("glitch2", 1);
        // A pulse past the filter threshold adds a clock that re-samples bit 4.
        send_frame(4, 5);
        for (int i = 7; i >= 0; i--) begin
            bits.push_back(tx_q[0][i]);
            if (i == 4) bits.push_back(tx_q[0][i]);
        end
        exp = '0;
        for (int k = 0; k < 8; k++) exp = {exp[6:0], bits[k]};
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL glitch5_count: got %0d expected 1", rx_q.size()); end
        checks++; if (got !== exp) begin errors++; $display("FAIL glitch5_data: got %h expected %h", got, exp); end
        checks++; if (n_stop !== 1) begin errors++; $display("FAIL glitch5_stop: got %0d expected 1", n_stop); end
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b1;
        clear_mon();
        bus_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_mid_values: got %h expected %h", out_vec(), RESET_VEC);
        end
        align();
        bus_stop();
        #(4*Q);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL reset_mid_no_valid: got %0d expected 0", rx_q.size()); end
        tx_q = '{8'h81};
        send_frame(-1, 0);
        check_frame_model("after_reset", 1);
    endtask

    task automatic test_abort();
        ack_en = 1'b1;
        clear_mon();
        bus_start();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
        bus_stop();
        #(4*Q);
        checks++; if (n_stop !== 1) begin errors++; $display("FAIL abort_stop: got %0d expected 1", n_stop); end
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", rx_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        // Idle slave must ignore a full byte clocked without a START.
        clear_mon();
        scl_m = 1'b0; #Q;
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), 0);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #(4*Q);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL idle_no_valid: got %0d expected 0", rx_q.size()); end
        checks++; if (n_drive !== 0) begin errors++; $display("FAIL idle_no_ack: got %0d expected 0", n_drive); end
    endtask

    task automatic test_repeated_start();
        int drv;
        logic [7:0] a, b;
        ack_en = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        clear_mon();
        ack_drv_q.delete();
        bus_start();
        send_byte(a, -1, 0, drv); ack_drv_q.push_back(drv);
        bus_start();
        send_byte(b, -1, 0, drv); ack_drv_q.push_back(drv);
        bus_stop();
        #(4*Q);
        checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL rstart_count: got %0d expected 2", rx_q.size()); end
        checks++; if (rx_q.size() < 2 || rx_q[0] !== a || rx_q[1] !== b) begin
            errors++; $display("FAIL rstart_data: expected %h %h", a, b);
        end
        checks++; if (idx_q.size() < 2 || idx_q[1] !== 0) begin errors++; $display("FAIL rstart_idx: expected second index 0"); end
        checks++; if (n_start !== 2) begin errors++; $display("FAIL rstart_start: got %0d expected 2", n_start); end
        checks++; if (ack_drv_q[1] !== 20) begin errors++; $display("FAIL rstart_ack: got %0d expected 20", ack_drv_q[1]); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            ack_en = 1'($urandom_range(0, 1));
            tx_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx_q.push_back(8'($urandom));
            send_frame(-1, 0);
            check_frame_model($sformatf("rand%0d", f), 1);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_saturate();
        ack_en = 1'b1;
        tx_q.delete();
        for (int i = 0; i < MAX_BYTES + 2; i++) tx_q.push_back(8'($urandom));
        send_frame(-1, 0);
        check_frame_model("saturate", 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_nack();
        test_glitch();
        test_reset_mid();
        test_abort();
        test_repeated_start();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
